uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Scheduler in front of the UART transmitter. Shares the TX among two requesters:
//  ch0 = 1-byte messages (register-file read data), ch1 = 2-byte messages (ALU result).
//  Sequences each message byte by byte into TX_TOP's P_DATA/DATA_VALID, pacing every
//  byte on the transmitter's BUSY. Same clock domain as the TX.
// PARAMETERS
//  WIDTH        8  byte width; ch1 message = 2*WIDTH
//  WIDTH_STATE  3  FSM state register width
// PORTS
//  CLK          in   1        single clock, all flops rising edge
//  RST          in   1        asynchronous, active-low reset
//  REQ0_DATA    in   WIDTH    ch0 message
//  REQ0_VALID   in   1        ch0 request; held with data until REQ0_READY
//  REQ0_READY   out  1        one-cycle accept pulse for ch0
//  REQ1_DATA    in   2*WIDTH  ch1 message, sent LSB byte first
//  REQ1_VALID   in   1        ch1 request; held with data until REQ1_READY
//  REQ1_READY   out  1        one-cycle accept pulse for ch1
//  TX_BUSY      in   1        BUSY from the transmitter
//  TX_P_DATA    out  WIDTH    to transmitter P_DATA
//  TX_DATA_VALID out 1        to transmitter DATA_VALID, one-cycle pulse per byte
//  SCHED_BUSY   out  1        high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, TX_P_DATA=0, TX_DATA_VALID=0, REQx_READY=0, SCHED_BUSY=0,
//   byte index=0, last_gnt=ch1. All outputs registered.
//  FSM: IDLE -> SEND -> WAIT_HI -> WAIT_LO -> (SEND for next byte | IDLE).
//  IDLE: grant only if TX_BUSY==0 and some VALID==1. At that edge: capture the granted
//   data into a holding register, set byte count (1 for ch0, 2 for ch1), go to SEND.
//   While TX_BUSY==1 in IDLE, no grant and no READY.
//  SEND (exactly 1 cycle): TX_DATA_VALID=1, TX_P_DATA=current byte. On the first byte
//   of a message, the granted REQx_READY=1 in the same cycle. Requester drops VALID
//   after seeing READY. A VALID still high one cycle after its READY is a new request.
//  WAIT_HI: TX_DATA_VALID=0; wait for TX_BUSY==1 (no timeout).
//  WAIT_LO: wait for TX_BUSY==0. Then, if bytes remain: go to SEND with the upper byte.
//   Otherwise go to IDLE.
//  Latency: VALID sampled at edge n -> READY and first DATA_VALID in cycle n+1.
//   Next byte's DATA_VALID is 1 cycle after TX_BUSY is sampled low.
//  TX_DATA_VALID never asserts while TX_BUSY==1. TX_P_DATA holds its last value otherwise.
//  A message is never interleaved: requests arriving mid-message wait in IDLE.
//  Simultaneous VALIDs: arbitration per CONFIGURATION. last_gnt is updated on every grant.
//  Reset mid-message: immediate return to reset state. Remaining bytes are dropped and
//   no further DATA_VALID is issued. Requester re-requests.
// CONFIGURATION
//  UART_TX_SCHED_RR_EN defined: round-robin on ties; the channel not in last_gnt wins.
//   First tie after reset goes to ch0.
//  Not defined: fixed priority, ch0 always wins ties (ch1 may starve). last_gnt unused.
// TESTING
//  1 REQ0 0xA5 alone, TX idle -> next cycle REQ0_READY=1, TX_DATA_VALID=1,
//    TX_P_DATA=0xA5; SCHED_BUSY stays high until TX_BUSY falls, then returns to IDLE.
//  2 REQ1 0x1234 -> 0x34 sent first. Second DATA_VALID (0x12) comes exactly 1 cycle after
//    TX_BUSY is sampled low. REQ1_READY pulses once only.
//  3 REQ0 and REQ1 held valid, re-asserted after each READY, RR_EN defined -> grant order
//    ch0, ch1, ch0. Without the macro -> ch0, ch0, ch0.
//  4 TX_BUSY forced high in IDLE with REQ0 valid -> no READY and no DATA_VALID.
//    Release TX_BUSY -> grant in the next cycle.
//  5 RST low during WAIT_HI of ch1 byte 0 -> all outputs 0 asynchronously.
//    After release: 0x12 is never sent and FSM is IDLE.
//  6 Random TX_BUSY stretch lengths 1..50 over 200 messages -> byte order correct and
//    DATA_VALID never coincides with TX_BUSY=1.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of the UART TX scheduler, bundled as one port.
// slave = the scheduler, master = the requesters plus the transmitter's BUSY.
interface uart_tx_sched_if #(
    parameter int WIDTH = 8
);
    // Handshake: a requester raises REQx_VALID with REQx_DATA and holds both until it
    // sees a one-cycle REQx_READY pulse, then drops VALID; a VALID still high the cycle
    // after READY counts as a fresh request. TX_DATA_VALID pulses once per byte and only
    // after TX_BUSY has been low at the preceding edge.
    logic [WIDTH-1:0]   REQ0_DATA;
    logic               REQ0_VALID;
    logic               REQ0_READY;
    logic [2*WIDTH-1:0] REQ1_DATA;
    logic               REQ1_VALID;
    logic               REQ1_READY;
    logic               TX_BUSY;
    logic [WIDTH-1:0]   TX_P_DATA;
    logic               TX_DATA_VALID;
    logic               SCHED_BUSY;

    modport slave (
        input  REQ0_DATA, REQ0_VALID, REQ1_DATA, REQ1_VALID, TX_BUSY,
        output REQ0_READY, REQ1_READY, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY
    );

    modport master (
        output REQ0_DATA, REQ0_VALID, REQ1_DATA, REQ1_VALID, TX_BUSY,
        input  REQ0_READY, REQ1_READY, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler in front of the UART transmitter (ch0: 1 byte, ch1: 2 bytes LSB first).
// Define UART_TX_SCHED_RR_EN for round-robin tie breaking; otherwise ch0 has fixed priority.
module uart_tx_sched #(
    parameter int WIDTH       = 8,
    parameter int WIDTH_STATE = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_tx_sched_if.slave         bus,
    output logic [WIDTH_STATE-1:0] dbg_state
);

    typedef enum logic [WIDTH_STATE-1:0] {
        IDLE    = WIDTH_STATE'(0),
        SEND    = WIDTH_STATE'(1),
        WAIT_HI = WIDTH_STATE'(2),
        WAIT_LO = WIDTH_STATE'(3)
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             dv_q, dv_d;
    logic             rdy0_q, rdy0_d;
    logic             rdy1_q, rdy1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hold_hi_q, hold_hi_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             idx_q, idx_d;
    logic             gnt1;

`ifdef UART_TX_SCHED_RR_EN
    // last_gnt: 0 = ch0, 1 = ch1; starts at ch1 so the first tie goes to ch0.
    logic last_gnt_q, last_gnt_d;
    assign gnt1 = bus.REQ1_VALID && (!bus.REQ0_VALID || !last_gnt_q);
`else
    assign gnt1 = bus.REQ1_VALID && !bus.REQ0_VALID;
`endif

    always_comb begin
        state_d   = state_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        rdy0_d    = 1'b0;
        rdy1_d    = 1'b0;
        hold_hi_d = hold_hi_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
`ifdef UART_TX_SCHED_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.TX_BUSY && (bus.REQ0_VALID || bus.REQ1_VALID)) begin
                    state_d = SEND;
                    dv_d    = 1'b1;
                    idx_d   = 1'b0;
                    if (gnt1) begin
                        p_data_d  = bus.REQ1_DATA[WIDTH-1:0];
                        hold_hi_d = bus.REQ1_DATA[2*WIDTH-1:WIDTH];
                        cnt_d     = 2'd2;
                        rdy1_d    = 1'b1;
`ifdef UART_TX_SCHED_RR_EN
                        last_gnt_d = 1'b1;
`endif
                    end else begin
                        p_data_d  = bus.REQ0_DATA;
                        hold_hi_d = '0;
                        cnt_d     = 2'd1;
                        rdy0_d    = 1'b1;
`ifdef UART_TX_SCHED_RR_EN
                        last_gnt_d = 1'b0;
`endif
                    end
                end
            end
            SEND: state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.TX_BUSY) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    if (!idx_q && cnt_q == 2'd2) begin
                        state_d  = SEND;
                        dv_d     = 1'b1;
                        p_data_d = hold_hi_q;
                        idx_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            busy_q    <= 1'b0;
            hold_hi_q <= '0;
            cnt_q     <= 2'd0;
            idx_q     <= 1'b0;
`ifdef UART_TX_SCHED_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
            busy_q    <= busy_d;
            hold_hi_q <= hold_hi_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
`ifdef UART_TX_SCHED_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign bus.TX_P_DATA     = p_data_q;
    assign bus.TX_DATA_VALID = dv_q;
    assign bus.REQ0_READY    = rdy0_q;
    assign bus.REQ1_READY    = rdy1_q;
    assign bus.SCHED_BUSY    = busy_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a negedge monitor models the transmitter BUSY
// and pops expected bytes/grants that the stimulus pushes as it issues requests.
module tb_uart_tx_sched;
    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] dbg_state;

    uart_tx_sched_if #(.WIDTH(W)) bus();

    uart_tx_sched #(.WIDTH(W), .WIDTH_STATE(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int   vectors     = 0;
    int   miscompares = 0;
    logic [W:0] exp_q[$];   // {second_byte_flag, byte}
    logic [0:0] gnt_q[$];   // expected channel of each READY
    logic model_busy    = 1'b0;
    logic force_busy    = 1'b0;
    int   busy_cnt      = 0;
    bit   rand_stretch  = 1'b0;
    int   fixed_stretch = 3;
    logic busy_hist     = 1'b0;
    logic cur_busy;
    logic [W:0] e;
    logic [0:0] g;

    assign bus.TX_BUSY = model_busy | force_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic pop_grant(input logic [0:0] ch);
        if (gnt_q.size() == 0) begin
            fail_now($sformatf("unexpected_ready ch%0d", ch));
        end else begin
            g = gnt_q.pop_front();
            check("grant_channel", 32'(ch), 32'(g));
        end
        check("ready_with_dv", 32'(bus.TX_DATA_VALID), 32'd1);
    endtask

    // Monitor and transmitter model: BUSY rises the cycle after DATA_VALID and stays
    // high for stretch+1 sampled edges.
    initial begin
        forever begin
            @(negedge CLK);
            cur_busy = bus.TX_BUSY;
            if (bus.TX_DATA_VALID) begin
                check("dv_while_busy", 32'(cur_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_byte got 0x%0h", bus.TX_P_DATA));
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(bus.TX_P_DATA), 32'(e[W-1:0]));
                    if (e[W]) check("hi_byte_after_busy_fall", 32'(busy_hist), 32'd1);
                end
            end
            if (bus.REQ0_READY) pop_grant(1'b0);
            if (bus.REQ1_READY) pop_grant(1'b1);
            if (bus.TX_DATA_VALID)
                busy_cnt = (rand_stretch ? int'($urandom_range(1, 50)) : fixed_stretch) + 1;
            else if (busy_cnt > 0)
                busy_cnt--;
            model_busy = (busy_cnt > 0);
            busy_hist  = cur_busy;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic push0(input logic [W-1:0] d);
        exp_q.push_back({1'b0, d});
        gnt_q.push_back(1'b0);
    endtask

    task automatic push1(input logic [2*W-1:0] d);
        exp_q.push_back({1'b0, d[W-1:0]});
        exp_q.push_back({1'b1, d[2*W-1:W]});
        gnt_q.push_back(1'b1);
    endtask

    task automatic drive0(input logic [W-1:0] d);
        int n;
        bus.REQ0_DATA  = d;
        bus.REQ0_VALID = 1'b1;
        n = 0;
        tick();
        while (!bus.REQ0_READY && n < 2000) begin
            tick();
            n++;
        end
        if (!bus.REQ0_READY) fail_now("req0_ready_timeout");
        bus.REQ0_VALID = 1'b0;
    endtask

    task automatic drive1(input logic [2*W-1:0] d);
        int n;
        bus.REQ1_DATA  = d;
        bus.REQ1_VALID = 1'b1;
        n = 0;
        tick();
        while (!bus.REQ1_READY && n < 2000) begin
            tick();
            n++;
        end
        if (!bus.REQ1_READY) fail_now("req1_ready_timeout");
        bus.REQ1_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.SCHED_BUSY || bus.TX_BUSY || exp_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail_now("idle_timeout");
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
    endtask

    initial begin
        RST            = 1'b0;
        bus.REQ0_DATA  = '0;
        bus.REQ0_VALID = 1'b0;
        bus.REQ1_DATA  = '0;
        bus.REQ1_VALID = 1'b0;
        tick();
        tick();
        check("rst_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("rst_dv", 32'(bus.TX_DATA_VALID), 32'd0);
        check("rst_ready0", 32'(bus.REQ0_READY), 32'd0);
        check("rst_ready1", 32'(bus.REQ1_READY), 32'd0);
        check("rst_sched_busy", 32'(bus.SCHED_BUSY), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        RST = 1'b1;
        tick();

        // Single ch0 byte on an idle transmitter.
        push0(8'hA5);
        bus.REQ0_DATA  = 8'hA5;
        bus.REQ0_VALID = 1'b1;
        tick();
        check("t1_ready0", 32'(bus.REQ0_READY), 32'd1);
        check("t1_dv", 32'(bus.TX_DATA_VALID), 32'd1);
        check("t1_p_data", 32'(bus.TX_P_DATA), 32'hA5);
        check("t1_sched_busy", 32'(bus.SCHED_BUSY), 32'd1);
        bus.REQ0_VALID = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.SCHED_BUSY && n < 200) begin
                tick();
                n++;
            end
        end
        check("t1_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);
        check("t1_tx_busy_low", 32'(bus.TX_BUSY), 32'd0);
        check("t1_state_idle", 32'(dbg_state), 32'd0);
        wait_idle();

        // Two-byte ch1 message, LSB first.
        push1(16'h1234);
        drive1(16'h1234);
        wait_idle();

        // Both channels contending; ch0 re-requests after each READY.
        pulse_reset();
`ifdef UART_TX_SCHED_RR_EN
        push0(8'h11);
        push1(16'hBBAA);
        push0(8'h22);
        push0(8'h33);
`else
        push0(8'h11);
        push0(8'h22);
        push0(8'h33);
        push1(16'hBBAA);
`endif
        fork
            begin
                drive0(8'h11);
                tick();
                drive0(8'h22);
                tick();
                drive0(8'h33);
            end
            drive1(16'hBBAA);
        join
        wait_idle();

        // Transmitter busy in IDLE blocks the grant.
        force_busy     = 1'b1;
        push0(8'h5A);
        bus.REQ0_DATA  = 8'h5A;
        bus.REQ0_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_ready", 32'(bus.REQ0_READY), 32'd0);
            check("t4_no_dv", 32'(bus.TX_DATA_VALID), 32'd0);
        end
        force_busy = 1'b0;
        tick();
        check("t4_ready_after_release", 32'(bus.REQ0_READY), 32'd1);
        check("t4_dv_after_release", 32'(bus.TX_DATA_VALID), 32'd1);
        bus.REQ0_VALID = 1'b0;
        wait_idle();

        // Reset during WAIT_HI of ch1 byte 0: the upper byte must never go out.
        fixed_stretch = 10;
        exp_q.push_back({1'b0, 8'h34});
        gnt_q.push_back(1'b1);
        bus.REQ1_DATA  = 16'h1234;
        bus.REQ1_VALID = 1'b1;
        tick();
        check("t5_ready1", 32'(bus.REQ1_READY), 32'd1);
        bus.REQ1_VALID = 1'b0;
        tick();
        check("t5_state_wait_hi", 32'(dbg_state), 32'd2);
        #1;
        RST = 1'b0;
        #1;
        check("t5_async_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("t5_async_dv", 32'(bus.TX_DATA_VALID), 32'd0);
        check("t5_async_ready1", 32'(bus.REQ1_READY), 32'd0);
        check("t5_async_sched_busy", 32'(bus.SCHED_BUSY), 32'd0);
        check("t5_async_state", 32'(dbg_state), 32'd0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("t5_state_idle", 32'(dbg_state), 32'd0);
        check("t5_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);
        check("t5_exp_drained", 32'(exp_q.size()), 32'd0);

        // Random busy stretches over 200 messages.
        rand_stretch = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if ($urandom_range(0, 1) == 1) begin
                push1({b ^ 8'h5A, ~b});
                drive1({b ^ 8'h5A, ~b});
            end else begin
                push0(b ^ 8'hC3);
                drive0(b ^ 8'hC3);
            end
        end
        wait_idle();

        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
